// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
// Processor-side bus of the buffered UART transmitter.
//
// Signals:
//   wr_en     store strobe to the UART transmit address (1 cycle per byte)
//   wr_data   byte to transmit, qualified by wr_en
//   tx_ready  FIFO not full (transmit-ready status bit)
//   tx_busy   FIFO non-empty or a frame is on the line
//   count     bytes currently held in the FIFO (0..2^DEPTH_LOG2)
//   overflow  sticky dropped-write flag (0 when the flag is compiled out)
//
// Handshake: a byte is accepted on a rising clk edge exactly when wr_en=1 and
// tx_ready=1 at that edge. wr_en with tx_ready=0 drops the byte; there is no
// back-pressure stall, the processor is expected to poll tx_ready first.
//
// Modports: master = processor side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  tx_ready;
    logic                  tx_busy;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output wr_en, wr_data,
        input  tx_ready, tx_busy, count, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output tx_ready, tx_busy, count, overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// UART transmitter (8N1, LSB first) fed by a circular byte FIFO.
//
// Ports:
//   clk         single clock, all registers update on its rising edge
//   rst         synchronous active-low reset
//   bus         uart_tx_buffered_if.slave: wr_en/wr_data in,
//               tx_ready/tx_busy/count/overflow out
//   serial_out  UART line, idles high, driven straight from a flop
//   dbg_state   current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Parameters: CLOCK_FREQ (Hz), BAUD_RATE (bit/s), DEPTH_LOG2 (1..6).
// Each line bit lasts CLOCK_FREQ/BAUD_RATE cycles (truncated).
//
// Build option: define UART_TX_OVERFLOW_FLAG_EN to get a sticky overflow
// flag that sets on any dropped write; otherwise overflow is tied to 0.
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_buffered_if.slave        bus,
    output logic                     serial_out,
    output logic [1:0]               dbg_state
);
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  serial_q, serial_d;
    logic [7:0]            mem_q [DEPTH];

    logic tx_ready;
    logic push;
    logic pop;
    logic bit_end;

    // Fullness alone decides acceptance, so a write into a full FIFO is
    // dropped even on a cycle where the FSM pops.
    assign tx_ready = (count_q != FULL_CNT);
    assign push     = bus.wr_en & tx_ready;
    assign bit_end  = (baud_q == BAUD_LAST);

    // FSM next state, shifter and bit timing.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the current state; it is registered, so the pin
    // trails every state or bit change by exactly one cycle.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
            default: serial_d = 1'b1;
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            serial_q <= serial_d;
        end
    end

    // Storage is not reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef UART_TX_OVERFLOW_FLAG_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && !tx_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.tx_ready = tx_ready;
    assign bus.tx_busy  = (count_q != '0) || (state_q != IDLE);
    assign bus.count    = count_q;
    assign serial_out   = serial_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered. A transaction-level model tracks
// FIFO occupancy and how long the transmitter stays occupied by each frame
// (10 bit times), pushes every accepted byte into exp_q, and a line monitor
// decodes serial_out and pops exp_q on each start bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;
    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 120;            // 1000/120 truncates to 8
    localparam int DL         = 3;
    localparam int B          = CLOCK_FREQ / BAUD_RATE;
    localparam int DEPTH      = 1 << DL;
    localparam int FRAME      = 10 * B;

`ifdef UART_TX_OVERFLOW_FLAG_EN
    localparam logic OVF_ON_DROP = 1'b1;
`else
    localparam logic OVF_ON_DROP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_out;
    logic [1:0] dbg_state;

    uart_tx_buffered_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_buffered #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .serial_out (serial_out),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int   m_cnt  = 0;   // bytes in FIFO
    int   m_left = 0;   // cycles the current frame still occupies the transmitter
    logic m_ovf  = 1'b0;
    bit   m_acc, m_pop;

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt  <= 0;
            m_left <= 0;
            m_ovf  <= 1'b0;
            exp_q.delete();
        end else begin
            m_acc = bus.wr_en && (m_cnt < DEPTH);
            m_pop = (m_left == 0) && (m_cnt > 0);
            if (m_acc) exp_q.push_back(bus.wr_data);
            m_cnt <= m_cnt + int'(m_acc) - int'(m_pop);
            if (m_pop)           m_left <= FRAME;
            else if (m_left > 0) m_left <= m_left - 1;
            if (bus.wr_en && m_cnt >= DEPTH && OVF_ON_DROP) m_ovf <= 1'b1;
        end
    end

    bit chk_en = 1'b0;

    // Status outputs against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count",    32'(bus.count),    32'(m_cnt));
            check("tx_ready", 32'(bus.tx_ready), 32'(m_cnt < DEPTH));
            check("tx_busy",  32'(bus.tx_busy),  32'((m_cnt != 0) || (m_left != 0)));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // ---------------- line monitor / scoreboard ----------------
    bit         mon_active = 1'b0;
    int         mon_n, mon_err, mon_pos;
    logic [7:0] mon_exp, mon_dec;
    logic       mon_eb;

    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
        end else if (chk_en) begin
            if (!mon_active && serial_out !== 1'b1) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                // Line lags the pop by one cycle; start must appear right then.
                check("start_timing", 32'(m_left), 32'(FRAME - 1));
                mon_active = 1'b1;
                mon_n      = 0;
                mon_err    = 0;
                mon_dec    = 8'h00;
            end
            if (mon_active) begin
                mon_pos = mon_n / B;
                if (mon_pos == 0)      mon_eb = 1'b0;
                else if (mon_pos == 9) mon_eb = 1'b1;
                else                   mon_eb = mon_exp[mon_pos-1];
                if (serial_out !== mon_eb) mon_err++;
                if (mon_pos >= 1 && mon_pos <= 8 && (mon_n % B) == B / 2)
                    mon_dec[mon_pos-1] = serial_out;
                mon_n++;
                if (mon_n == FRAME) begin
                    check("frame_wave_errors", 32'(mon_err), 32'd0);
                    check("frame_byte", 32'(mon_dec), 32'(mon_exp));
                    mon_active = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((m_cnt != 0 || m_left != 0 || mon_active) && n < 5000) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 32'(n < 5000), 32'd1);
        repeat (3) tick();
    endtask

    // Wait until the next edge is a pop; optionally also require a full FIFO.
    task automatic wait_pop_edge(input string name, input bit need_full);
        int n = 0;
        while (!(m_left == 0 && m_cnt > 0 && (!need_full || m_cnt == DEPTH)) && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_found"}, 32'(n < 2000), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b, n, lows;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst         = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;

        // Reset state
        check("rst_serial",   32'(serial_out),   32'd1);
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_tx_busy",  32'(bus.tx_busy),  32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b1;
        tick();

        // Single byte 0x55 and write-to-start latency of 2 cycles
        wr(8'h55);
        check("lat_cycle0", 32'(serial_out), 32'd1);
        tick();
        check("lat_cycle1", 32'(serial_out), 32'd1);
        tick();
        check("lat_cycle2", 32'(serial_out), 32'd0);
        wait_drain("single");

        // Fill: 9 back-to-back writes, first byte pops immediately
        for (int i = 0; i < 9; i++) wr(8'hA0 + 8'(i));
        check("fill_count",    32'(bus.count),    32'd8);
        check("fill_tx_ready", 32'(bus.tx_ready), 32'd0);
        wr(8'hEE);
        check("fill_drop_count", 32'(bus.count),    32'd8);
        check("fill_overflow",   32'(bus.overflow), 32'(OVF_ON_DROP));

        // Write while full on the pop cycle: dropped, count falls by one
        wait_pop_edge("full_pop", 1'b1);
        wr(8'hF1);
        check("full_pop_count", 32'(bus.count), 32'd7);

        // Write on a pop cycle when not full: count unchanged
        wait_pop_edge("pop_write", 1'b0);
        wr(8'hF2);
        check("pop_write_count", 32'(bus.count), 32'd7);
        check("pop_write_ovf",   32'(bus.overflow), 32'(OVF_ON_DROP));
        wait_drain("fill");

        // Ordered stream 0x00..0x13 gated by tx_ready (pointers wrap)
        b = 0;
        n = 0;
        while (b < 20 && n < 20000) begin
            if (bus.tx_ready) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'(b);
                b++;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
            n++;
        end
        bus.wr_en = 1'b0;
        check("stream_written", 32'(b), 32'd20);
        wait_drain("stream");

        // Random traffic, including ungated writes into a full FIFO
        for (int i = 0; i < 800; i++) begin
            bus.wr_en   = ($urandom_range(0, 11) == 0);
            bus.wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        bus.wr_en = 1'b0;
        wait_drain("random");

        // Reset during DATA bit 3 with 4 bytes queued
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
        n = 0;
        while (m_left != FRAME - 4 * B - B / 2 && n < 2000) begin
            tick();
            n++;
        end
        check("midrst_reach_bit3", 32'(n < 2000), 32'd1);
        check("midrst_queued",     32'(bus.count), 32'd4);
        rst = 1'b0;
        tick();
        check("midrst_serial",   32'(serial_out),   32'd1);
        check("midrst_count",    32'(bus.count),    32'd0);
        check("midrst_tx_busy",  32'(bus.tx_busy),  32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        rst  = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (serial_out !== 1'b1) lows++;
        end
        check("midrst_no_frames", 32'(lows), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
